// File: rtl/cpu_writeback_if.sv
// MEM-stage result bundle into writeback, plus the register-file write port it drives.
interface cpu_writeback_if;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned CTL_W  = 3;

    logic              validM;
    logic [DATA_W-1:0] aluResultM;
    logic [DATA_W-1:0] memDataM;
    logic              memReadyM;
    logic              memReadM;
    logic [REG_W-1:0]  writeRegM;
    logic [CTL_W-1:0]  WBcontrolsM;
    logic [DATA_W-1:0] pcPlus2M;
    logic              haltM;
    logic              stallM;
    logic [DATA_W-1:0] wrData;
    logic [REG_W-1:0]  regWriteAddress;
    logic              regWrite;

    modport master (
        output validM, aluResultM, memDataM, memReadyM, memReadM,
               writeRegM, WBcontrolsM, pcPlus2M, haltM,
        input  stallM, wrData, regWriteAddress, regWrite
    );

    modport slave (
        input  validM, aluResultM, memDataM, memReadyM, memReadM,
               writeRegM, WBcontrolsM, pcPlus2M, haltM,
        output stallM, wrData, regWriteAddress, regWrite
    );
endinterface

// File: rtl/cpu_writeback.sv
// MEM/WB pipeline register and writeback stage: result select, load stall,
// HLT retirement and retire/stall performance counters.
module cpu_writeback #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    cpu_writeback_if.slave   bus,
    output logic             halt,
    output logic             memTimeout,
    output logic [CNT_W-1:0] retireCount,
    output logic [CNT_W-1:0] stallCount
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic              validW;
    logic              memToRegW;
    logic              regWriteW;
    logic              pcSwitchW;
    logic              haltW;
    logic [DATA_W-1:0] aluResultW;
    logic [DATA_W-1:0] memDataW;
    logic [DATA_W-1:0] pcPlus2W;
    logic [REG_W-1:0]  writeRegW;
    logic [WAIT_W-1:0] waitCnt;
    logic              stallLoad;
    logic              haltRetiring;
    logic              blockCapture;

    always_comb begin
        stallLoad    = bus.validM & bus.memReadM & ~bus.memReadyM & ~halt;
        haltRetiring = validW & haltW;
        // Nothing behind an HLT may enter W, including the instruction right after it.
        blockCapture = halt | haltRetiring;
    end

    assign bus.stallM          = stallLoad;
    assign bus.wrData          = pcSwitchW ? pcPlus2W : (memToRegW ? memDataW : aluResultW);
    assign bus.regWriteAddress = writeRegW;
    assign bus.regWrite        = validW & regWriteW & (writeRegW != '0) & ~haltW;

    always_ff @(posedge clk) begin
        if (rst) begin
            validW      <= 1'b0;
            memToRegW   <= 1'b0;
            regWriteW   <= 1'b0;
            pcSwitchW   <= 1'b0;
            haltW       <= 1'b0;
            aluResultW  <= '0;
            memDataW    <= '0;
            pcPlus2W    <= '0;
            writeRegW   <= '0;
            waitCnt     <= '0;
            halt        <= 1'b0;
            memTimeout  <= 1'b0;
            retireCount <= '0;
            stallCount  <= '0;
        end else begin
            if (blockCapture || stallLoad) begin
                validW <= 1'b0;
            end else begin
                validW                              <= bus.validM;
                {memToRegW, regWriteW, pcSwitchW}   <= bus.WBcontrolsM;
                aluResultW                          <= bus.aluResultM;
                pcPlus2W                            <= bus.pcPlus2M;
                writeRegW                           <= bus.writeRegM;
                haltW                               <= bus.haltM;
                if (bus.memReadM) begin
                    memDataW <= bus.memDataM;
                end
            end

            if (haltRetiring) begin
                halt <= 1'b1;
            end

            if (validW && !halt && retireCount != '1) begin
                retireCount <= retireCount + CNT_W'(1);
            end

            if (stallLoad && stallCount != '1) begin
                stallCount <= stallCount + CNT_W'(1);
            end

            // Wait counter holds at its last value; the load keeps stalling after timeout.
            if (stallLoad) begin
                if (waitCnt == WAIT_LAST) begin
                    memTimeout <= 1'b1;
                end else begin
                    waitCnt <= waitCnt + WAIT_W'(1);
                end
            end else begin
                waitCnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cpu_writeback.sv
// Directed bench for cpu_writeback with a cycle-level behavioural model and literal spot checks.
module tb_cpu_writeback;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned MEM_TIMEOUT = 4;
    localparam int          CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             halt;
    logic             memTimeout;
    logic [CNT_W-1:0] retireCount;
    logic [CNT_W-1:0] stallCount;

    cpu_writeback_if bus();

    cpu_writeback #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .halt       (halt),
        .memTimeout (memTimeout),
        .retireCount(retireCount),
        .stallCount (stallCount)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    bit checkEn = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Model: what the register file sees next cycle, and the architectural status.
    bit          mValid, mWe, mIsHlt, mHalt, mHltSeen, mTimeout;
    logic [15:0] mData;
    logic [3:0]  mAddr;
    int          mRetire, mStall, mRun;

    always @(posedge clk) begin
        bit stall;
        if (rst) begin
            mValid = 0; mWe = 0; mIsHlt = 0; mHalt = 0; mHltSeen = 0; mTimeout = 0;
            mData = '0; mAddr = '0; mRetire = 0; mStall = 0; mRun = 0;
        end else begin
            stall = bus.validM && bus.memReadM && !bus.memReadyM && !mHalt;
            if (mValid && !mHalt && mRetire < CNT_MAX) mRetire++;
            if (mValid && mIsHlt) mHalt = 1;
            if (stall) begin
                if (mStall < CNT_MAX) mStall++;
                mRun++;
                if (mRun >= int'(MEM_TIMEOUT)) mTimeout = 1;
            end else begin
                mRun = 0;
            end
            if (bus.validM && !stall && !mHltSeen) begin
                mValid = 1;
                mIsHlt = bus.haltM;
                mAddr  = bus.writeRegM;
                mData  = bus.WBcontrolsM[0] ? bus.pcPlus2M :
                         bus.WBcontrolsM[2] ? bus.memDataM : bus.aluResultM;
                mWe    = bus.WBcontrolsM[1] && (bus.writeRegM != 4'd0) && !bus.haltM;
                if (bus.haltM) mHltSeen = 1;
            end else begin
                mValid = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            chk("regWrite", 32'(bus.regWrite), 32'(mValid && mWe));
            if (mValid) begin
                chk("wrData", 32'(bus.wrData), 32'(mData));
                chk("regWriteAddress", 32'(bus.regWriteAddress), 32'(mAddr));
            end
            chk("halt", 32'(halt), 32'(mHalt));
            chk("memTimeout", 32'(memTimeout), 32'(mTimeout));
            chk("retireCount", 32'(retireCount), 32'(mRetire));
            chk("stallCount", 32'(stallCount), 32'(mStall));
            chk("stallM", 32'(bus.stallM),
                32'(bus.validM && bus.memReadM && !bus.memReadyM && !mHalt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit rd, input bit rdy, input logic [2:0] ctl,
                         input logic [3:0] wr, input logic [15:0] alu, input logic [15:0] md,
                         input logic [15:0] pc, input bit h);
        bus.validM      = v;
        bus.memReadM    = rd;
        bus.memReadyM   = rdy;
        bus.WBcontrolsM = ctl;
        bus.writeRegM   = wr;
        bus.aluResultM  = alu;
        bus.memDataM    = md;
        bus.pcPlus2M    = pc;
        bus.haltM       = h;
    endtask

    task automatic idle();
        drive(0, 0, 0, 3'b000, 4'd0, 16'h0, 16'h0, 16'h0, 0);
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, " regWrite"}, 32'(bus.regWrite), 32'd0);
        chk({tag, " wrData"}, 32'(bus.wrData), 32'd0);
        chk({tag, " regWriteAddress"}, 32'(bus.regWriteAddress), 32'd0);
        chk({tag, " halt"}, 32'(halt), 32'd0);
        chk({tag, " memTimeout"}, 32'(memTimeout), 32'd0);
        chk({tag, " retireCount"}, 32'(retireCount), 32'd0);
        chk({tag, " stallCount"}, 32'(stallCount), 32'd0);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkAllZero("reset");
        checkEn = 1'b1;

        // ALU op to R5
        drive(1, 0, 0, 3'b010, 4'd5, 16'h1234, 16'h0, 16'h0, 0);
        tick();
        chk("alu wrData", 32'(bus.wrData), 32'h1234);
        chk("alu addr", 32'(bus.regWriteAddress), 32'd5);
        chk("alu regWrite", 32'(bus.regWrite), 32'd1);
        idle();
        tick();
        chk("alu retire", 32'(retireCount), 32'd1);

        // Load with three wait cycles
        drive(1, 1, 0, 3'b110, 4'd7, 16'hAAAA, 16'h0, 16'h0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("load stallM", 32'(bus.stallM), 32'd1);
            tick();
            chk("load no write", 32'(bus.regWrite), 32'd0);
        end
        drive(1, 1, 1, 3'b110, 4'd7, 16'hAAAA, 16'hBEEF, 16'h0, 0);
        #1;
        chk("load ready stallM", 32'(bus.stallM), 32'd0);
        chk("load stallCount", 32'(stallCount), 32'd3);
        tick();
        chk("load wrData", 32'(bus.wrData), 32'hBEEF);
        chk("load regWrite", 32'(bus.regWrite), 32'd1);
        chk("load addr", 32'(bus.regWriteAddress), 32'd7);

        // PCS to R3, then to R0
        drive(1, 0, 0, 3'b011, 4'd3, 16'hDEAD, 16'h0, 16'h0042, 0);
        tick();
        chk("pcs wrData", 32'(bus.wrData), 32'h0042);
        chk("pcs regWrite", 32'(bus.regWrite), 32'd1);
        drive(1, 0, 0, 3'b011, 4'd0, 16'hDEAD, 16'h0, 16'h0042, 0);
        tick();
        chk("r0 regWrite", 32'(bus.regWrite), 32'd0);
        idle();
        tick();
        chk("r0 retire", 32'(retireCount), 32'd4);

        // Load that never completes
        drive(1, 1, 0, 3'b110, 4'd2, 16'h0, 16'h0, 16'h0, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("timeout early", 32'(memTimeout), 32'd0);
        tick();
        chk("timeout set", 32'(memTimeout), 32'd1);
        chk("timeout stallM", 32'(bus.stallM), 32'd1);
        chk("timeout stallCount", 32'(stallCount), 32'd7);
        tick();
        rst = 1'b1;
        #1;
        chk("stallM in reset", 32'(bus.stallM), 32'd1);
        tick();
        checkAllZero("mid-stall reset");
        rst = 1'b0;
        idle();
        tick();

        // Back-to-back ops saturate the retire counter
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 3'b010, 4'((i % 15) + 1), 16'(i * 16'h0101), 16'h0, 16'h0, 0);
            tick();
        end
        idle();
        tick();
        tick();
        chk("retire saturated", 32'(retireCount), 32'd15);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // HLT followed by an ALU op
        drive(1, 0, 0, 3'b010, 4'd1, 16'h1111, 16'h0, 16'h0, 0);
        tick();
        drive(1, 0, 0, 3'b010, 4'd6, 16'h6666, 16'h0, 16'h0, 1);
        tick();
        chk("hlt no write", 32'(bus.regWrite), 32'd0);
        chk("hlt retire pre", 32'(retireCount), 32'd1);
        chk("hlt not yet", 32'(halt), 32'd0);
        drive(1, 0, 0, 3'b010, 4'd4, 16'h4444, 16'h0, 16'h0, 0);
        tick();
        chk("halt set", 32'(halt), 32'd1);
        chk("post-hlt no write", 32'(bus.regWrite), 32'd0);
        drive(1, 1, 0, 3'b110, 4'd4, 16'h0, 16'h0, 16'h0, 0);
        #1;
        chk("halted stallM", 32'(bus.stallM), 32'd0);
        tick();
        tick();
        chk("halted retire", 32'(retireCount), 32'd2);
        chk("halted no write", 32'(bus.regWrite), 32'd0);
        chk("halted stallCount", 32'(stallCount), 32'd0);

        @(negedge clk);
        checkEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/cpu_writeback.md
Name: cpu_writeback

Overview:
- MEM/WB pipeline register and writeback stage; the producer end of the ID-stage register-file write interface (wrData, regWriteAddress, regWrite).
- Captures MEM-stage results and selects the writeback value: ALU result, load data or PC+2 (PCS).
- Stalls upstream while a variable-latency data-memory load is pending.
- Detects retirement of HLT and keeps retire and stall performance counters.

Parameters:
- CNT_W, 16, width of the retire and stall counters; counters saturate at all-ones.
- MEM_TIMEOUT, 64, number of consecutive cycles of waiting on one load before memTimeout sets.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- validM  input  1  MEM stage holds a real instruction; 0 means bubble.
- aluResultM  input  16  ALU result from EX/MEM.
- memDataM  input  16  load data from data memory; meaningful only when memReadyM=1.
- memReadyM  input  1  data memory has load data for the current load.
- memReadM  input  1  the MEM instruction is a load.
- writeRegM  input  4  destination register number.
- WBcontrolsM  input  3  {memToReg, regWrite, pcSwitch}, same bundle order as produced by decode.
- pcPlus2M  input  16  PC+2 of the MEM instruction, used by PCS.
- haltM  input  1  the MEM instruction is HLT.
- stallM  output  1  combinational; hold MEM and all earlier stages this cycle.
- wrData  output  16  register-file write data.
- regWriteAddress  output  4  register-file write address.
- regWrite  output  1  register-file write enable.
- halt  output  1  sticky; HLT has retired.
- memTimeout  output  1  sticky error; a load waited MEM_TIMEOUT cycles.
- retireCount  output  CNT_W  number of valid instructions retired.
- stallCount  output  CNT_W  number of cycles with stallM=1.

Behaviour:
- stallM = validM & memReadM & ~memReadyM & ~halt.
- W register capture each cycle:
  - halt=1: validW<=0.
  - stallM=1: validW<=0 (bubble); other W fields don't-care.
  - otherwise: validW<=validM; W fields <= M inputs (memDataM captured only when memReadM).
- Latency: exactly one cycle from M-input capture to the outputs; the outputs are driven combinationally from the W registers.
- wrData priority: pcSwitchW ? pcPlus2W : memToRegW ? memDataW : aluResultW.
- regWrite = validW & regWriteW & (regWriteAddress!=0) & ~haltW; R0 is never written.
- regWriteAddress = writeRegW at all times; wrData is driven even when regWrite=0.
- HLT handling:
  - halt sets in the cycle after the edge that captures a valid haltM.
  - haltW suppresses the HLT instruction's own write.
  - Once halt=1, no further captures, writes or counter increments occur; halt clears only on rst.
- Wait counter:
  - Increments each cycle stallM=1; clears when stallM=0.
  - When it reaches MEM_TIMEOUT-1 while stallM=1, memTimeout sets at the next edge (sticky until rst).
  - The stall itself continues; the timeout does not abort the load.
- retireCount increments at each edge where validW=1 and halt=0 (HLT itself counts); saturates at 2^CNT_W-1.
- stallCount increments at each edge where stallM=1; saturates.
- Simultaneous events:
  - memReadyM arriving in the same cycle as the load: no stall, capture happens normally.
  - rst has priority over every capture and increment.
- Reset values: validW=0, all W fields 0, wrData=0, regWriteAddress=0, regWrite=0, halt=0, memTimeout=0, retireCount=0, stallCount=0, wait counter=0.
- Reset asserted mid-stall: stallM is still driven by the inputs; all internal state returns to reset values at that edge.

Test Plan:
- ALU op: validM=1, WBcontrolsM=3'b010, writeRegM=5, aluResultM=16'h1234 -> next cycle regWrite=1, regWriteAddress=5, wrData=16'h1234; retireCount=1.
- Load, 3-cycle memory: memReadM=1, memToReg=1, memReadyM low for 3 cycles, then memDataM=16'hBEEF -> stallM=1 for 3 cycles, stallCount=3, no write during the stall, then one write of 16'hBEEF.
- PCS and R0: pcSwitch=1, pcPlus2M=16'h0042, writeRegM=3 -> wrData=16'h0042; the same op with writeRegM=0 -> regWrite=0, retireCount still increments.
- HLT: haltM=1 valid, then an ALU op to R4 -> halt=1, no write for either instruction, retireCount frozen at pre-HLT count+1.
- Timeout: MEM_TIMEOUT=4, memReadyM held 0 -> memTimeout=1 after 4 stall cycles, stallM stays 1; assert rst -> all outputs 0.
- Saturation: CNT_W=4, 20 back-to-back valid ops -> retireCount=15.
